lsu_bus_ctrl: RTL and testbench

- Load/store bus sequencer directly upstream of the load-data formatter.
- Accepts one memory operation at a time from the execute stage and places store data on the big-endian 32-bit data bus, with byte-lane enables.
- Runs the request/acknowledge transaction, with a timeout, and captures read data.
- Presents the captured raw word plus the held fn3 and address LSBs to the formatter, which performs the endian swap and sign/zero extension.

---
 rtl/lsu_bus_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
// Load/store bus sequencer sitting directly upstream of the load-data
// formatter. It accepts one memory operation at a time, places store data
// on a big-endian 32-bit bus with byte-lane enables, runs a req/ack
// transaction bounded by a timeout, and captures the raw read word. The
// formatter performs the endian swap and the sign/zero extension.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid/op_ready   : operation handshake from execute (ready only in IDLE)
//   op_store, op_fn3    : 1 = store; funct3 (size in [1:0], [2] = unsigned)
//   op_addr, op_wdata   : byte address, little-endian store operand
//   bus_req/bus_ack     : bus request held until ack or timeout
//   bus_we, bus_addr    : write strobe, word address (op_addr[31:2])
//   bus_be, bus_wdata   : byte enables (bit3 = byte offset 0), lane-placed data
//   bus_rdata           : big-endian read word, valid with bus_ack
//   resp_valid/ready    : result handshake to the consumer
//   resp_fault          : [0] misaligned, [1] bus timeout
//   ld_data, ld_fn3,
//   ld_addr_low         : raw word, held funct3 and address LSBs to formatter
// ---------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [2:0]  op_fn3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_fault,
    output logic [31:0] ld_data,
    output logic [2:0]  ld_fn3,
    output logic [1:0]  ld_addr_low
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Last counter value before the timeout fires; the request is therefore
    // held for exactly TIMEOUT_CYCLES cycles when no ack arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Natural alignment check for the access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~a[0];
            default: ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    // Byte-lane enables; byte offset k maps to enable bit 3-k.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b1000 >> a;
            2'd1:    be = a[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Big-endian lane placement of the little-endian operand. Narrow data is
    // replicated across the unused lanes so the bus sees it at any offset.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] r);
        logic [31:0] wd;
        case (size)
            2'd0:    wd = {4{r[7:0]}};
            2'd1:    wd = {2{r[7:0], r[15:8]}};
            default: wd = {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
        return wd;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_store;
    logic             r_op_ready;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [29:0]      r_bus_addr;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;
    logic             r_resp_valid;
    logic [1:0]       r_resp_fault;
    logic [31:0]      r_ld_data;
    logic [2:0]       r_ld_fn3;
    logic [1:0]       r_ld_addr_low;

    logic             w_aligned;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;

    // Decode alignment and lane placement of the presented operation.
    always_comb begin
        w_aligned = is_aligned(op_fn3[1:0], op_addr[1:0]);
        w_be      = lane_be(op_fn3[1:0], op_addr[1:0]);
        if (op_store) begin
            w_wdata = lane_wdata(op_fn3[1:0], op_wdata);
        end else begin
            w_wdata = 32'h0000_0000;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_store       <= 1'b0;
            r_op_ready    <= 1'b1;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 30'd0;
            r_bus_be      <= 4'b0000;
            r_bus_wdata   <= 32'h0000_0000;
            r_resp_valid  <= 1'b0;
            r_resp_fault  <= 2'b00;
            r_ld_data     <= 32'h0000_0000;
            r_ld_fn3      <= 3'b000;
            r_ld_addr_low <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_ld_fn3      <= op_fn3;
                        r_ld_addr_low <= op_addr[1:0];
                        r_store       <= op_store;
                        r_op_ready    <= 1'b0;
                        if (!w_aligned) begin
                            // Misaligned: report straight away, no bus cycle.
                            r_resp_fault <= 2'b01;
                            r_resp_valid <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= op_store;
                            r_bus_addr  <= op_addr[31:2];
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_cnt       <= '0;
                            r_state     <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus_ack) begin
                        if (!r_store) begin
                            r_ld_data <= bus_rdata;
                        end
                        r_resp_fault <= 2'b00;
                        r_resp_valid <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_resp_fault <= 2'b10;
                        r_resp_valid <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_op_ready   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_bus_req    <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_op_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready    = r_op_ready;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_be      = r_bus_be;
    assign bus_wdata   = r_bus_wdata;
    assign resp_valid  = r_resp_valid;
    assign resp_fault  = r_resp_fault;
    assign ld_data     = r_ld_data;
    assign ld_fn3      = r_ld_fn3;
    assign ld_addr_low = r_ld_addr_low;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_ctrl
// Self-checking bench for lsu_bus_ctrl (TIMEOUT_CYCLES = 4). Expected
// responses are pushed to a scoreboard queue when an operation is driven and
// popped when the DUT completes the response handshake. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        op_store = 1'b0;
    logic [2:0]  op_fn3 = 3'b000;
    logic [31:0] op_addr = 32'h0;
    logic [31:0] op_wdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_fault;
    logic [31:0] ld_data;
    logic [2:0]  ld_fn3;
    logic [1:0]  ld_addr_low;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic [1:0]  alow;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mdl_ld = 32'h0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
        .op_fn3(op_fn3), .op_addr(op_addr), .op_wdata(op_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_fault(resp_fault), .ld_data(ld_data), .ld_fn3(ld_fn3),
        .ld_addr_low(ld_addr_low)
    );

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference lane model: byte offset k lands on lane 3-k, carrying operand
    // byte (k mod size) so narrow data is replicated.
    task automatic lane_model(input logic [2:0] fn3, input logic [1:0] al, input logic [31:0] r,
                              output logic [3:0] be, output logic [31:0] wd, output bit mis);
        int n;
        int j;
        n  = (fn3[1:0] == 2'd0) ? 1 : ((fn3[1:0] == 2'd1) ? 2 : 4);
        be = 4'b0000;
        wd = 32'h0;
        for (int k = 0; k < 4; k++) begin
            j = k % n;
            wd[(3-k)*8 +: 8] = r[j*8 +: 8];
            if (k >= int'(al) && k < int'(al) + n) be[3-k] = 1'b1;
        end
        mis = (int'(al) % n) != 0;
    endtask

    // Complete the response handshake and compare against the scoreboard.
    task automatic take_resp(input int hold);
        exp_t e;
        int   w;
        w = 0;
        while (!resp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("resp_valid_seen", 32'(resp_valid), 32'd1);
        if (sb_q.size() == 0) begin
            check_val("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q[0];
            for (int i = 0; i < hold; i++) begin
                check_val("hold_valid", 32'(resp_valid), 32'd1);
                check_val("hold_op_ready", 32'(op_ready), 32'd0);
                check_val("hold_ld_data", ld_data, e.data);
                check_val("hold_ld_fn3", 32'(ld_fn3), 32'(e.fn3));
                @(negedge clk);
            end
            resp_ready = 1'b1;
            if (resp_valid) begin
                e = sb_q.pop_front();
                check_val("resp_fault", 32'(resp_fault), 32'(e.fault));
                check_val("ld_data", ld_data, e.data);
                check_val("ld_fn3", 32'(ld_fn3), 32'(e.fn3));
                check_val("ld_addr_low", 32'(ld_addr_low), 32'(e.alow));
            end
            @(negedge clk);
            resp_ready = 1'b0;
            check_val("resp_drop", 32'(resp_valid), 32'd0);
            check_val("op_ready_back", 32'(op_ready), 32'd1);
        end
    endtask

    // Drive one operation; ack_at = bus cycle index of the ack (-1: never).
    task automatic do_op(input logic st, input logic [2:0] fn3, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input int hold);
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        bit          mis;
        bit          acked;
        exp_t        e;
        int          cyc;
        int          w;
        lane_model(fn3, addr[1:0], wd, e_be, e_wd, mis);
        acked = (ack_at >= 0) && (ack_at < TO);
        @(negedge clk);
        w = 0;
        while (!op_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_store = st; op_fn3 = fn3; op_addr = addr; op_wdata = wd;
        e.fn3  = fn3;
        e.alow = addr[1:0];
        if (mis) begin
            e.fault = 2'b01;
        end else if (acked) begin
            e.fault = 2'b00;
            if (!st) mdl_ld = rd;
        end else begin
            e.fault = 2'b10;
        end
        e.data = mdl_ld;
        sb_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0;
        op_wdata = $urandom;
        if (mis) begin
            check_val("mis_no_req", 32'(bus_req), 32'd0);
            check_val("mis_resp_1cyc", 32'(resp_valid), 32'd1);
        end else begin
            check_val("bus_req_rise", 32'(bus_req), 32'd1);
            check_val("bus_we", 32'(bus_we), 32'(st));
            check_val("bus_be", 32'(bus_be), 32'(e_be));
            check_val("bus_wdata", bus_wdata, st ? e_wd : 32'h0);
            cyc = 0;
            while (bus_req && cyc < 64) begin
                check_val("bus_addr", 32'(bus_addr), 32'(addr[31:2]));
                if (cyc == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
                cyc++;
                @(negedge clk);
                bus_ack = 1'b0;
                bus_rdata = $urandom;
            end
            check_val("req_cycles", 32'(cyc), acked ? 32'(ack_at + 1) : 32'(TO));
            check_val("resp_after_bus", 32'(resp_valid), 32'd1);
        end
        take_resp(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check_val("rst_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_op_ready", 32'(op_ready), 32'd1);
        check_val("rst_ld_data", ld_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: load word with immediate ack
        do_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h1122_3344, 0);
        // 2: store half at offset 2, store byte at offset 1, store word, load byte
        do_op(1'b1, 3'b001, 32'h0000_0102, 32'hAABB_CCDD, 1, 32'h0, 0);
        do_op(1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 0, 32'h0, 0);
        do_op(1'b1, 3'b010, 32'h0000_0200, 32'h0102_0304, 2, 32'h0, 0);
        do_op(1'b1, 3'b001, 32'h0000_0200, 32'h0000_BEEF, 0, 32'h0, 0);
        do_op(1'b0, 3'b100, 32'h0000_0203, 32'h0, 2, 32'h8899_AABB, 0);
        // ack outside BUS must not touch ld_data
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        // 3: misaligned operations
        do_op(1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0, 0);
        do_op(1'b1, 3'b001, 32'h0000_0101, 32'h1234_5678, 0, 32'h0, 0);
        // 4: timeout, ld_data retained
        do_op(1'b0, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0, 0);
        // 5: ack on last timeout cycle, response held for 5 cycles
        do_op(1'b0, 3'b000, 32'h0000_0301, 32'h0, TO - 1, 32'hCAFE_F00D, 5);

        // 6: reset during BUS
        @(negedge clk);
        op_valid = 1'b1; op_store = 1'b0; op_fn3 = 3'b010; op_addr = 32'h0000_0400;
        @(negedge clk);
        op_valid = 1'b0;
        check_val("pre_rst_req", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        #1;
        check_val("async_rst_req", 32'(bus_req), 32'd0);
        check_val("async_rst_be", 32'(bus_be), 32'd0);
        check_val("async_rst_addr", 32'(bus_addr), 32'd0);
        check_val("async_rst_ld", ld_data, 32'h0);
        check_val("async_rst_fn3", 32'(ld_fn3), 32'd0);
        check_val("async_rst_ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        bus_ack = 1'b0;
        check_val("rst_ack_ignored", ld_data, 32'h0);
        rst_n = 1'b1;
        mdl_ld = 32'h0;
        do_op(1'b0, 3'b010, 32'h0000_0404, 32'h0, 1, 32'h5566_7788, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
